// File: rtl/rgmii_pkg.sv
// Shared RGMII transmit-decode types: speed encodings, TXC period class limits
// and the registered GMII byte record.
package rgmii_pkg;

   typedef logic [1:0] speed_t;

   localparam speed_t SPEED_10   = 2'b00;
   localparam speed_t SPEED_100  = 2'b01;
   localparam speed_t SPEED_1000 = 2'b10;

   // TXC period limits in clk cycles, inclusive on both ends
   localparam int CLS_1000_MAX = 2;
   localparam int CLS_100_MIN  = 3;
   localparam int CLS_100_MAX  = 10;
   localparam int CLS_10_MIN   = 40;
   localparam int CLS_10_MAX   = 63;

   typedef struct packed {
      logic [7:0] txd;
      logic       en;
      logic       er;
   } gmii_byte_t;

   // 2'b11 is treated as gigabit, like 2'b10
   function automatic speed_t speed_norm(input speed_t s);
      return s[1] ? SPEED_1000 : s;
   endfunction

endpackage

// File: rtl/rgmii_speed_detect.sv
// TXC period measurement and speed classifier with a lock counter; fed with the
// TXC rising-edge strobe from the decoder top.
module rgmii_speed_detect
   import rgmii_pkg::*;
#(
   parameter int PERIOD_W   = 6,
   parameter int LOCK_COUNT = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   rise_i,
   output speed_t speed_det_o,
   output logic   locked_o
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [MATCH_W-1:0]  match_q, match_d;
   speed_t              det_q, det_d;
   logic [PERIOD_W:0]   period;
   logic                cls_vld;
   speed_t              cls;

   // one extra bit so a saturated counter classifies as 64, which is no class
   assign period = {1'b0, cnt_q} + (PERIOD_W+1)'(1);

   always_comb begin
      cls_vld = 1'b0;
      cls     = SPEED_10;
      if (period <= (PERIOD_W+1)'(CLS_1000_MAX)) begin
         cls_vld = 1'b1;
         cls     = SPEED_1000;
      end else if (period >= (PERIOD_W+1)'(CLS_100_MIN) &&
                   period <= (PERIOD_W+1)'(CLS_100_MAX)) begin
         cls_vld = 1'b1;
         cls     = SPEED_100;
      end else if (period >= (PERIOD_W+1)'(CLS_10_MIN) &&
                   period <= (PERIOD_W+1)'(CLS_10_MAX)) begin
         cls_vld = 1'b1;
         cls     = SPEED_10;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      match_d = match_q;
      det_d   = det_q;
      if (rise_i) begin
         cnt_d = '0;
         if (cls_vld) begin
            if (match_q != '0 && cls == det_q) begin
               if (match_q < MATCH_W'(LOCK_COUNT))
                  match_d = match_q + MATCH_W'(1);
            end else begin
               match_d = MATCH_W'(1);
               det_d   = cls;
            end
         end
      end else if (cnt_q == CNT_MAX) begin
         match_d = '0;
      end else begin
         cnt_d = cnt_q + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         match_q <= '0;
         det_q   <= SPEED_10;
      end else begin
         cnt_q   <= cnt_d;
         match_q <= match_d;
         det_q   <= det_d;
      end
   end

   assign speed_det_o = det_q;
   assign locked_o    = (match_q >= MATCH_W'(LOCK_COUNT));

endmodule

// File: rtl/rgmii_phy_tx_decode.sv
// PHY-side RGMII TX decoder: DDR half-cycle samples to valid-strobed GMII bytes.
// Define RGMII_SPEED_DETECT_EN to follow the detected TXC speed once locked.
//
// state | meaning
// PH_LO | waiting for the low nibble of a byte
// PH_HI | low nibble stored, next data nibble completes the byte
module rgmii_phy_tx_decode
   import rgmii_pkg::*;
#(
   parameter int PERIOD_W   = 6,
   parameter int LOCK_COUNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_txc_1,
   input  logic       in_txc_2,
   input  logic [3:0] in_td_1,
   input  logic [3:0] in_td_2,
   input  logic       in_ctl_1,
   input  logic       in_ctl_2,
   input  logic [1:0] speed,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       gmii_valid,
   output logic       odd_nibble_err,
   output logic [1:0] speed_det,
   output logic       locked
);

   localparam logic [0:0] PH_LO = 1'b0;
   localparam logic [0:0] PH_HI = 1'b1;

   if (PERIOD_W < 6 || LOCK_COUNT < 1) begin : g_bad_param
      $error("PERIOD_W must reach the 10M class and LOCK_COUNT must be positive");
   end

   logic       prev_txc_q;
   logic       rise, fall;
   speed_t     eff_raw, eff, eff_q;
   logic [0:0] phase_q, phase_d;
   logic       have_rise_q, have_rise_d;
   logic [3:0] nib_q, nib_d, lo_q, lo_d, nib_cur;
   logic       ctl_r_q, ctl_r_d, er_lo_q, er_lo_d, ctl_r_cur;
   logic       nib_er;
   gmii_byte_t out_q, out_d;
   logic       valid_q, valid_d, odd_q, odd_d;

   assign rise = ~prev_txc_q & in_txc_1;
   assign fall = (in_txc_1 & ~in_txc_2) | (prev_txc_q & ~in_txc_1);

`ifdef RGMII_SPEED_DETECT_EN
   speed_t det_speed;
   logic   det_locked;

   rgmii_speed_detect #(
      .PERIOD_W   (PERIOD_W),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_speed_detect (
      .clk         (clk),
      .rst         (rst),
      .rise_i      (rise),
      .speed_det_o (det_speed),
      .locked_o    (det_locked)
   );

   assign speed_det = det_speed;
   assign locked    = det_locked;
   assign eff_raw   = det_locked ? det_speed : speed;
`else
   speed_t speed_det_q;
   logic   locked_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed_det_q <= SPEED_10;
         locked_q    <= 1'b0;
      end else begin
         speed_det_q <= speed;
         locked_q    <= 1'b1;
      end
   end

   assign speed_det = speed_det_q;
   assign locked    = locked_q;
   assign eff_raw   = speed;
`endif

   assign eff = speed_norm(eff_raw);

   // a rise and fall in the same cycle must see this cycle's nibble and ctl
   assign nib_cur   = rise ? in_td_1  : nib_q;
   assign ctl_r_cur = rise ? in_ctl_1 : ctl_r_q;
   assign nib_er    = ctl_r_cur ^ in_ctl_1;

   always_comb begin
      phase_d     = phase_q;
      have_rise_d = have_rise_q;
      nib_d       = nib_q;
      ctl_r_d     = ctl_r_q;
      lo_d        = lo_q;
      er_lo_d     = er_lo_q;
      out_d       = out_q;
      valid_d     = 1'b0;
      odd_d       = 1'b0;
      if (eff != eff_q) begin
         phase_d     = PH_LO;
         have_rise_d = 1'b0;
      end else if (eff == SPEED_1000) begin
         phase_d     = PH_LO;
         have_rise_d = 1'b0;
         if (rise) begin
            out_d.txd = {in_td_2, in_td_1};
            out_d.en  = in_ctl_1;
            out_d.er  = in_ctl_1 ^ in_ctl_2;
            valid_d   = 1'b1;
         end
      end else begin
         if (rise) begin
            nib_d       = in_td_1;
            ctl_r_d     = in_ctl_1;
            have_rise_d = 1'b1;
         end
         if (fall && (rise || have_rise_q)) begin
            have_rise_d = 1'b0;
            if (in_ctl_1) begin
               if (phase_q == PH_LO) begin
                  lo_d    = nib_cur;
                  er_lo_d = nib_er;
                  phase_d = PH_HI;
               end else begin
                  out_d.txd = {nib_cur, lo_q};
                  out_d.en  = 1'b1;
                  out_d.er  = er_lo_q | nib_er;
                  valid_d   = 1'b1;
                  phase_d   = PH_LO;
               end
            end else begin
               out_d.txd = 8'h00;
               out_d.en  = 1'b0;
               out_d.er  = nib_er;
               valid_d   = 1'b1;
               odd_d     = (phase_q == PH_HI);
               phase_d   = PH_LO;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_txc_q  <= 1'b0;
         eff_q       <= SPEED_10;
         phase_q     <= PH_LO;
         have_rise_q <= 1'b0;
         nib_q       <= '0;
         ctl_r_q     <= 1'b0;
         lo_q        <= '0;
         er_lo_q     <= 1'b0;
         out_q       <= '0;
         valid_q     <= 1'b0;
         odd_q       <= 1'b0;
      end else begin
         prev_txc_q  <= in_txc_2;
         eff_q       <= eff;
         phase_q     <= phase_d;
         have_rise_q <= have_rise_d;
         nib_q       <= nib_d;
         ctl_r_q     <= ctl_r_d;
         lo_q        <= lo_d;
         er_lo_q     <= er_lo_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         odd_q       <= odd_d;
      end
   end

   assign gmii_txd       = out_q.txd;
   assign gmii_tx_en     = out_q.en;
   assign gmii_tx_er     = out_q.er;
   assign gmii_valid     = valid_q;
   assign odd_nibble_err = odd_q;

endmodule

// File: tb/tb_rgmii_phy_tx_decode.sv
// Bench for rgmii_phy_tx_decode: gigabit vector table, 10/100 nibble frames
// checked through an expected-byte queue, reset and speed-detect sequences.
module tb_rgmii_phy_tx_decode;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_txc_1, in_txc_2, in_ctl_1, in_ctl_2;
   logic [3:0] in_td_1, in_td_2;
   logic [1:0] speed;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en, gmii_tx_er, gmii_valid, odd_nibble_err, locked;
   logic [1:0] speed_det;

   rgmii_phy_tx_decode dut (
      .clk            (clk),
      .rst            (rst),
      .in_txc_1       (in_txc_1),
      .in_txc_2       (in_txc_2),
      .in_td_1        (in_td_1),
      .in_td_2        (in_td_2),
      .in_ctl_1       (in_ctl_1),
      .in_ctl_2       (in_ctl_2),
      .speed          (speed),
      .gmii_txd       (gmii_txd),
      .gmii_tx_en     (gmii_tx_en),
      .gmii_tx_er     (gmii_tx_er),
      .gmii_valid     (gmii_valid),
      .odd_nibble_err (odd_nibble_err),
      .speed_det      (speed_det),
      .locked         (locked)
   );

   always #4 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] txd;
      logic       en, er, odd;
      int         at;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [3:0] d1, d2;
      logic       c1, c2;
      logic [7:0] txd;
      logic       en, er;
   } vec_t;
   vec_t vt[12];

   // nibble-mode reference state
   logic       m_ph;
   logic [3:0] m_lo;
   logic       m_erlo;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic drv(input logic t1, t2, input logic [3:0] d1, d2, input logic c1, c2);
      @(negedge clk);
      in_txc_1 = t1; in_txc_2 = t2;
      in_td_1  = d1; in_td_2  = d2;
      in_ctl_1 = c1; in_ctl_2 = c2;
   endtask

   task automatic push(input logic [7:0] txd, input logic en, er, odd);
      exp_t e;
      e.txd = txd; e.en = en; e.er = er; e.odd = odd; e.at = cyc + 1;
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic model_fall(input logic [3:0] n, input logic cr, cf);
      logic er;
      er = cr ^ cf;
      if (cf) begin
         if (!m_ph) begin
            m_lo = n; m_erlo = er; m_ph = 1'b1;
         end else begin
            push({n, m_lo}, 1'b1, m_erlo | er, 1'b0);
            m_ph = 1'b0;
         end
      end else begin
         push(8'h00, 1'b0, er, m_ph);
         m_ph = 1'b0;
      end
   endtask

   // one TXC period: high half, fall cycle (1,0), low half; fast = gigabit decode expected
   task automatic nib(input int per, input logic [3:0] n, input logic cr, cf, input bit fast);
      int h;
      h = per / 2;
      for (int c = 0; c < per; c++) begin
         if (c < h) begin
            drv(1'b1, 1'b1, n, n, cr, cr);
            if (c == 0 && fast) push({n, n}, cr, 1'b0, 1'b0);
         end else if (c == h) begin
            drv(1'b1, 1'b0, n, n, cf, cf);
            if (!fast) model_fall(n, cr, cf);
         end else begin
            drv(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
         end
      end
   endtask

   task automatic do_reset(input logic [1:0] spd);
      @(negedge clk);
      rst = 1'b1;
      speed = spd;
      in_txc_1 = 1'b0; in_txc_2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      m_ph = 1'b0; m_lo = 4'h0; m_erlo = 1'b0;
   endtask

   // scoreboard: every strobe pops one expected byte due on this very cycle
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sbq.size() != 0 && sbq[0].at < cyc) begin
            n_checks++;
            n_fail++;
            e = sbq.pop_front();
            $display("FAIL missed_strobe: no strobe at cyc %0d, expected txd=%h en=%b er=%b odd=%b",
                     e.at, e.txd, e.en, e.er, e.odd);
         end
         if (gmii_valid || odd_nibble_err) begin
            n_checks++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_strobe: got txd=%h en=%b er=%b valid=%b odd=%b at cyc %0d, expected none",
                        gmii_txd, gmii_tx_en, gmii_tx_er, gmii_valid, odd_nibble_err, cyc);
            end else begin
               e = sbq.pop_front();
               if (gmii_valid !== 1'b1 || gmii_txd !== e.txd || gmii_tx_en !== e.en ||
                   gmii_tx_er !== e.er || odd_nibble_err !== e.odd || cyc != e.at) begin
                  n_fail++;
                  $display("FAIL gmii_byte: got txd=%h en=%b er=%b valid=%b odd=%b cyc=%0d, expected txd=%h en=%b er=%b valid=1 odd=%b cyc=%0d",
                           gmii_txd, gmii_tx_en, gmii_tx_er, gmii_valid, odd_nibble_err, cyc,
                           e.txd, e.en, e.er, e.odd, e.at);
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 7; i++) vt[i] = '{4'h5, 4'h5, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
      vt[7]  = '{4'h5, 4'hD, 1'b1, 1'b1, 8'hD5, 1'b1, 1'b0};
      vt[8]  = '{4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[9]  = '{4'hF, 4'hA, 1'b1, 1'b0, 8'hAF, 1'b1, 1'b1};
      vt[10] = '{4'h3, 4'hC, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};
      vt[11] = '{4'h9, 4'h6, 1'b1, 1'b1, 8'h69, 1'b1, 1'b0};

      rst = 1'b1; speed = 2'b10;
      in_txc_1 = 1'b0; in_txc_2 = 1'b0; in_td_1 = 4'h0; in_td_2 = 4'h0;
      in_ctl_1 = 1'b0; in_ctl_2 = 1'b0;
      m_ph = 1'b0; m_lo = 4'h0; m_erlo = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd", gmii_txd, 8'h00);
      check("rst_en", {7'd0, gmii_tx_en}, 8'h00);
      check("rst_er", {7'd0, gmii_tx_er}, 8'h00);
      check("rst_valid", {7'd0, gmii_valid}, 8'h00);
      check("rst_odd", {7'd0, odd_nibble_err}, 8'h00);
      check("rst_speed_det", {6'd0, speed_det}, 8'h00);
      check("rst_locked", {7'd0, locked}, 8'h00);
      rst = 1'b0;
      idle(3);
`ifndef RGMII_SPEED_DETECT_EN
      check("mirror_speed_det_1000", {6'd0, speed_det}, 8'h02);
      check("mirror_locked", {7'd0, locked}, 8'h01);
`endif

      // gigabit: one byte per beat, registered one clk later
      for (int i = 0; i < 12; i++) begin
         drv(1'b1, 1'b0, vt[i].d1, vt[i].d2, vt[i].c1, vt[i].c2);
         push(vt[i].txd, vt[i].en, vt[i].er, 1'b0);
      end
      idle(4);
      check("gig_hold_txd", gmii_txd, 8'h69);

      do_reset(2'b01);
      idle(3);
`ifndef RGMII_SPEED_DETECT_EN
      check("mirror_speed_det_100", {6'd0, speed_det}, 8'h01);
`endif
      // 100M preamble tail: 5,5,5,D then idle
      nib(5, 4'h5, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h5, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h5, 1'b1, 1'b1, 1'b0);
      nib(5, 4'hD, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h0, 1'b0, 1'b0, 1'b0);
      nib(5, 4'h0, 1'b0, 1'b0, 1'b0);
      // odd frame: 3 nibbles then idle, then a clean frame
      nib(5, 4'h1, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h2, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h3, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h0, 1'b0, 1'b0, 1'b0);
      nib(5, 4'h4, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h5, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h0, 1'b0, 1'b0, 1'b0);
      // ctl_r=0, ctl_f=1 on the high nibble; then idle nibble carrying er
      nib(5, 4'h4, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h7, 1'b0, 1'b1, 1'b0);
      nib(5, 4'h0, 1'b1, 1'b0, 1'b0);
      nib(5, 4'h0, 1'b0, 1'b0, 1'b0);
`ifdef RGMII_SPEED_DETECT_EN
      check("det_100_speed", {6'd0, speed_det}, 8'h01);
      check("det_100_locked", {7'd0, locked}, 8'h01);
`endif

      // reset mid-frame with a stored low nibble
      nib(5, 4'h1, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h2, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h3, 1'b1, 1'b1, 1'b0);
      check("pre_rst_txd", gmii_txd, 8'h21);
      #2 rst = 1'b1;
      #1;
      check("async_rst_txd", gmii_txd, 8'h00);
      check("async_rst_en", {7'd0, gmii_tx_en}, 8'h00);
      check("async_rst_valid", {7'd0, gmii_valid}, 8'h00);
      check("async_rst_locked", {7'd0, locked}, 8'h00);
      check("async_rst_speed_det", {6'd0, speed_det}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      m_ph = 1'b0;
      idle(3);
      nib(5, 4'hA, 1'b1, 1'b1, 1'b0);
      nib(5, 4'hB, 1'b1, 1'b1, 1'b0);
      nib(5, 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef RGMII_SPEED_DETECT_EN
      // speed input says 1000M, TXC runs at period 50: lock to 10M, then decode nibbles
      do_reset(2'b10);
      idle(70);
      for (int i = 0; i < 5; i++) nib(50, 4'h0, 1'b0, 1'b0, 1'b1);
      check("det_10_speed", {6'd0, speed_det}, 8'h00);
      check("det_10_locked", {7'd0, locked}, 8'h01);
      nib(50, 4'h5, 1'b1, 1'b1, 1'b0);
      nib(50, 4'hD, 1'b1, 1'b1, 1'b0);
      nib(50, 4'h0, 1'b0, 1'b0, 1'b0);
      idle(70);
      check("txc_stop_locked", {7'd0, locked}, 8'h00);
      check("txc_stop_speed_hold", {6'd0, speed_det}, 8'h00);
`endif

      idle(10);
      check("queue_drained", 8'(sbq.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
